// File: rtl/plab3_mem_sec_mem_guard_pkg.sv
// rtl/plab3_mem_sec_mem_guard_pkg.sv - shared defs for the secure memory guard: domains, states, mem msg layout
package plab3_mem_sec_mem_guard_pkg;

  // Security domain encodings carried alongside each cache request
  localparam logic DOMAIN_LOW  = 1'b0;
  localparam logic DOMAIN_HIGH = 1'b1;

  // Guard FSM states (3-bit encoding, IDLE=0 .. DENY=5)
  typedef enum logic [2:0] {
    STATE_IDLE     = 3'd0,
    STATE_CHECK    = 3'd1,
    STATE_MEM_REQ  = 3'd2,
    STATE_MEM_WAIT = 3'd3,
    STATE_RESP     = 3'd4,
    STATE_DENY     = 3'd5
  } guard_state_t;

  // VC memory message type encodings
  localparam int         MEM_MSG_TYPE_NBITS  = 3;
  localparam logic [2:0] MEM_MSG_TYPE_READ   = 3'd0;
  localparam logic [2:0] MEM_MSG_TYPE_WRITE  = 3'd1;
  localparam logic [2:0] MEM_MSG_TYPE_INIT   = 3'd2;
  localparam int         MEM_RESP_TEST_NBITS = 2;

  // Request layout (MSB..LSB): type | opaque | addr | len | data
  // Response layout (MSB..LSB): type | opaque | test | len | data
  function automatic int mem_len_nbits(input int d);
    return $clog2(d / 8);
  endfunction

  function automatic int mem_req_msg_nbits(input int o, input int a, input int d);
    return MEM_MSG_TYPE_NBITS + o + a + mem_len_nbits(d) + d;
  endfunction

  function automatic int mem_resp_msg_nbits(input int o, input int d);
    return MEM_MSG_TYPE_NBITS + o + MEM_RESP_TEST_NBITS + mem_len_nbits(d) + d;
  endfunction

  function automatic int mem_req_addr_lsb(input int d);
    return d + mem_len_nbits(d);
  endfunction

  function automatic int mem_req_opaque_lsb(input int a, input int d);
    return d + mem_len_nbits(d) + a;
  endfunction

  function automatic int mem_req_type_lsb(input int o, input int a, input int d);
    return d + mem_len_nbits(d) + a + o;
  endfunction

  function automatic int mem_resp_opaque_lsb(input int d);
    return d + mem_len_nbits(d) + MEM_RESP_TEST_NBITS;
  endfunction

  function automatic int mem_resp_type_lsb(input int o, input int d);
    return d + mem_len_nbits(d) + MEM_RESP_TEST_NBITS + o;
  endfunction

endpackage

// File: rtl/plab3_mem_sec_addr_checker.sv
// rtl/plab3_mem_sec_addr_checker.sv - combinational deny decision for low-domain access to the high region
module plab3_mem_sec_addr_checker
  import plab3_mem_sec_mem_guard_pkg::*;
#(
  parameter int             abw         = 32,
  parameter logic [abw-1:0] p_high_base = 32'h0000_8000
)(
  input  logic [abw-1:0] addr,
  input  logic           domain,
  output logic           deny
);

  // Only low-domain requests at or above the base are refused; unsigned compare
  assign deny = (domain == DOMAIN_LOW) && (addr >= p_high_base);

endmodule

// File: rtl/plab3_mem_sec_mem_guard.sv
// rtl/plab3_mem_sec_mem_guard.sv - blocking guard between secure cache and memory; optional PLAB3_MEM_SEC_GUARD_VIOL_CNT_EN adds viol_count
module plab3_mem_sec_mem_guard
  import plab3_mem_sec_mem_guard_pkg::*;
#(
  parameter int             p_opaque_nbits = 8,
  parameter int             abw            = 32,
  parameter int             clw            = 128,
  parameter logic [abw-1:0] p_high_base    = 32'h0000_8000,
  localparam int            c_req_nbits    = mem_req_msg_nbits(p_opaque_nbits, abw, clw),
  localparam int            c_resp_nbits   = mem_resp_msg_nbits(p_opaque_nbits, clw)
)(
  input  logic                    clk,
  input  logic                    reset,

  input  logic [c_req_nbits-1:0]  cachereq_msg,
  input  logic                    cachereq_domain,
  input  logic                    cachereq_val,
  output logic                    cachereq_rdy,

  output logic [c_resp_nbits-1:0] cacheresp_msg,
  output logic                    cacheresp_domain,
  output logic                    cacheresp_val,
  input  logic                    cacheresp_rdy,
  output logic                    insecure,

  output logic [c_req_nbits-1:0]  memreq_msg,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,

  input  logic [c_resp_nbits-1:0] memresp_msg,
  input  logic                    memresp_val,
`ifdef PLAB3_MEM_SEC_GUARD_VIOL_CNT_EN
  output logic [7:0]              viol_count,
`endif
  output logic                    memresp_rdy
);

  localparam int c_req_addr_lsb    = mem_req_addr_lsb(clw);
  localparam int c_req_opaque_lsb  = mem_req_opaque_lsb(abw, clw);
  localparam int c_req_type_lsb    = mem_req_type_lsb(p_opaque_nbits, abw, clw);
  localparam int c_resp_opaque_lsb = mem_resp_opaque_lsb(clw);
  localparam int c_resp_type_lsb   = mem_resp_type_lsb(p_opaque_nbits, clw);

  guard_state_t                state;
  logic [c_req_nbits-1:0]      req_reg;
  logic                        dom_reg;
  logic [c_resp_nbits-1:0]     resp_reg;

  logic [abw-1:0]              req_addr;
  logic [MEM_MSG_TYPE_NBITS-1:0] req_type;
  logic [p_opaque_nbits-1:0]   req_opaque;
  logic                        deny;
  logic [c_resp_nbits-1:0]     deny_msg;

  assign req_addr   = req_reg[c_req_addr_lsb +: abw];
  assign req_opaque = req_reg[c_req_opaque_lsb +: p_opaque_nbits];
  assign req_type   = req_reg[c_req_type_lsb +: MEM_MSG_TYPE_NBITS];

  // The held request is presented unchanged to memory; the held response to the cache
  assign memreq_msg    = req_reg;
  assign cacheresp_msg = resp_reg;

  plab3_mem_sec_addr_checker #(
    .abw         (abw),
    .p_high_base (p_high_base)
  ) addr_checker (
    .addr   (req_addr),
    .domain (dom_reg),
    .deny   (deny)
  );

  // Denial response echoes type and opaque so the cache can match it; len, test and data are zero
  always_comb begin
    deny_msg = '0;
    deny_msg[c_resp_type_lsb +: MEM_MSG_TYPE_NBITS] = req_type;
    deny_msg[c_resp_opaque_lsb +: p_opaque_nbits]   = req_opaque;
  end

  // Guard FSM with registered handshake outputs set on entry to each state
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= STATE_IDLE;
      req_reg          <= '0;
      dom_reg          <= DOMAIN_LOW;
      resp_reg         <= '0;
      cachereq_rdy     <= 1'b1;
      memresp_rdy      <= 1'b1;
      memreq_val       <= 1'b0;
      cacheresp_val    <= 1'b0;
      cacheresp_domain <= DOMAIN_LOW;
      insecure         <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          // Stale memory responses are accepted and discarded here
          if (cachereq_val) begin
            req_reg      <= cachereq_msg;
            dom_reg      <= cachereq_domain;
            cachereq_rdy <= 1'b0;
            memresp_rdy  <= 1'b0;
            state        <= STATE_CHECK;
          end
        end
        STATE_CHECK: begin
          if (deny) begin
            resp_reg         <= deny_msg;
            cacheresp_val    <= 1'b1;
            cacheresp_domain <= DOMAIN_LOW;
            insecure         <= 1'b1;
            state            <= STATE_DENY;
          end else begin
            memreq_val <= 1'b1;
            state      <= STATE_MEM_REQ;
          end
        end
        STATE_MEM_REQ: begin
          if (memreq_rdy) begin
            memreq_val  <= 1'b0;
            memresp_rdy <= 1'b1;
            state       <= STATE_MEM_WAIT;
          end
        end
        STATE_MEM_WAIT: begin
          if (memresp_val) begin
            resp_reg         <= memresp_msg;
            memresp_rdy      <= 1'b0;
            cacheresp_val    <= 1'b1;
            cacheresp_domain <= dom_reg;
            insecure         <= 1'b0;
            state            <= STATE_RESP;
          end
        end
        STATE_RESP, STATE_DENY: begin
          if (cacheresp_rdy) begin
            cacheresp_val    <= 1'b0;
            cacheresp_domain <= DOMAIN_LOW;
            insecure         <= 1'b0;
            cachereq_rdy     <= 1'b1;
            memresp_rdy      <= 1'b1;
            state            <= STATE_IDLE;
          end
        end
        default: begin
          cachereq_rdy  <= 1'b1;
          memresp_rdy   <= 1'b1;
          memreq_val    <= 1'b0;
          cacheresp_val <= 1'b0;
          insecure      <= 1'b0;
          state         <= STATE_IDLE;
        end
      endcase
    end
  end

`ifdef PLAB3_MEM_SEC_GUARD_VIOL_CNT_EN
  // Count delivered denials, holding at the top value instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      viol_count <= 8'h00;
    end else if ((state == STATE_DENY) && cacheresp_rdy && (viol_count != 8'hFF)) begin
      viol_count <= viol_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_plab3_mem_sec_mem_guard.sv
// tb/tb_plab3_mem_sec_mem_guard.sv - randomized self-checking bench for plab3_mem_sec_mem_guard
module tb_plab3_mem_sec_mem_guard;

  localparam int REQ_W  = 3 + 8 + 32 + 4 + 128;
  localparam int RESP_W = 3 + 8 + 2 + 4 + 128;
  localparam logic [31:0] HIGH_BASE = 32'h0000_8000;

  logic              clk = 1'b0;
  logic              reset;
  logic [REQ_W-1:0]  cachereq_msg;
  logic              cachereq_domain;
  logic              cachereq_val;
  logic              cachereq_rdy;
  logic [RESP_W-1:0] cacheresp_msg;
  logic              cacheresp_domain;
  logic              cacheresp_val;
  logic              cacheresp_rdy;
  logic              insecure;
  logic [REQ_W-1:0]  memreq_msg;
  logic              memreq_val;
  logic              memreq_rdy;
  logic [RESP_W-1:0] memresp_msg;
  logic              memresp_val;
  logic              memresp_rdy;
`ifdef PLAB3_MEM_SEC_GUARD_VIOL_CNT_EN
  logic [7:0]        viol_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  plab3_mem_sec_mem_guard dut (
    .clk              (clk),
    .reset            (reset),
    .cachereq_msg     (cachereq_msg),
    .cachereq_domain  (cachereq_domain),
    .cachereq_val     (cachereq_val),
    .cachereq_rdy     (cachereq_rdy),
    .cacheresp_msg    (cacheresp_msg),
    .cacheresp_domain (cacheresp_domain),
    .cacheresp_val    (cacheresp_val),
    .cacheresp_rdy    (cacheresp_rdy),
    .insecure         (insecure),
    .memreq_msg       (memreq_msg),
    .memreq_val       (memreq_val),
    .memreq_rdy       (memreq_rdy),
    .memresp_msg      (memresp_msg),
    .memresp_val      (memresp_val),
`ifdef PLAB3_MEM_SEC_GUARD_VIOL_CNT_EN
    .viol_count       (viol_count),
`endif
    .memresp_rdy      (memresp_rdy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction against the reference rules; caller leaves the DUT idle, #1 after an edge
  task automatic do_txn(input logic dom, input logic [31:0] addr, input logic [2:0] typ,
                        input logic [7:0] opq, input logic [3:0] len, input logic [127:0] data,
                        input int mreq_stall, input int wait_gap, input int cresp_stall,
                        input logic [127:0] rdata);
    logic [REQ_W-1:0]  req;
    logic [RESP_W-1:0] rsp;
    logic [RESP_W-1:0] exp_rsp;
    logic              exp_deny;
    req      = {typ, opq, addr, len, data};
    rsp      = {typ, opq ^ 8'h5A, 2'b00, len, rdata};
    exp_deny = (dom == 1'b0) && (addr >= HIGH_BASE);

    checks++;
    if (cachereq_rdy !== 1'b1) begin
      errors++; $display("FAIL idle_rdy got %b exp 1", cachereq_rdy);
    end
    cachereq_msg = req; cachereq_domain = dom; cachereq_val = 1'b1;
    step();
    cachereq_val = 1'b0; cachereq_msg = '0; cachereq_domain = 1'b0;

    checks++;
    if ({cachereq_rdy, memreq_val, cacheresp_val} !== 3'b000) begin
      errors++; $display("FAIL check_cycle got %b exp 000", {cachereq_rdy, memreq_val, cacheresp_val});
    end
    step();

    if (exp_deny) begin
      exp_rsp = {typ, opq, 2'b00, 4'h0, 128'h0};
      for (int i = 0; i <= cresp_stall; i++) begin
        checks++;
        if ({cacheresp_val, insecure, cacheresp_domain, memreq_val, cachereq_rdy} !== 5'b11000) begin
          errors++; $display("FAIL deny_ctl got %b exp 11000 addr %h",
                             {cacheresp_val, insecure, cacheresp_domain, memreq_val, cachereq_rdy}, addr);
        end
        checks++;
        if (cacheresp_msg !== exp_rsp) begin
          errors++; $display("FAIL deny_msg got %h exp %h", cacheresp_msg, exp_rsp);
        end
        if (i == cresp_stall) cacheresp_rdy = 1'b1;
        step();
        cacheresp_rdy = 1'b0;
      end
    end else begin
      for (int i = 0; i <= mreq_stall; i++) begin
        checks++;
        if ({memreq_val, cachereq_rdy, cacheresp_val, memresp_rdy} !== 4'b1000) begin
          errors++; $display("FAIL memreq_ctl got %b exp 1000 addr %h",
                             {memreq_val, cachereq_rdy, cacheresp_val, memresp_rdy}, addr);
        end
        checks++;
        if (memreq_msg !== req) begin
          errors++; $display("FAIL memreq_msg got %h exp %h", memreq_msg, req);
        end
        if (i == mreq_stall) memreq_rdy = 1'b1;
        step();
        memreq_rdy = 1'b0;
      end
      for (int i = 0; i <= wait_gap; i++) begin
        checks++;
        if ({memreq_val, memresp_rdy, cacheresp_val, cachereq_rdy} !== 4'b0100) begin
          errors++; $display("FAIL memwait_ctl got %b exp 0100",
                             {memreq_val, memresp_rdy, cacheresp_val, cachereq_rdy});
        end
        if (i == wait_gap) begin
          memresp_val = 1'b1; memresp_msg = rsp;
        end
        step();
        memresp_val = 1'b0; memresp_msg = '0;
      end
      for (int i = 0; i <= cresp_stall; i++) begin
        checks++;
        if ({cacheresp_val, insecure, cacheresp_domain, memreq_val, memresp_rdy, cachereq_rdy}
            !== {1'b1, 1'b0, dom, 3'b000}) begin
          errors++; $display("FAIL resp_ctl got %b exp %b",
                             {cacheresp_val, insecure, cacheresp_domain, memreq_val, memresp_rdy, cachereq_rdy},
                             {1'b1, 1'b0, dom, 3'b000});
        end
        checks++;
        if (cacheresp_msg !== rsp) begin
          errors++; $display("FAIL resp_msg got %h exp %h", cacheresp_msg, rsp);
        end
        if (i == cresp_stall) cacheresp_rdy = 1'b1;
        step();
        cacheresp_rdy = 1'b0;
      end
    end

    checks++;
    if ({cacheresp_val, cachereq_rdy, insecure, memresp_rdy, memreq_val} !== 5'b01010) begin
      errors++; $display("FAIL back_idle got %b exp 01010",
                         {cacheresp_val, cachereq_rdy, insecure, memresp_rdy, memreq_val});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cachereq_msg = '0; cachereq_domain = 1'b0; cachereq_val = 1'b0;
    cacheresp_rdy = 1'b0; memreq_rdy = 1'b0; memresp_msg = '0; memresp_val = 1'b0;
    step(); step();
    checks++;
    if ({cachereq_rdy, cacheresp_val, insecure, memreq_val, memresp_rdy} !== 5'b10001) begin
      errors++; $display("FAIL reset_ctl got %b exp 10001",
                         {cachereq_rdy, cacheresp_val, insecure, memreq_val, memresp_rdy});
    end
    checks++;
    if ({memreq_msg, cacheresp_msg} !== '0) begin
      errors++; $display("FAIL reset_msgs got %h %h exp 0", memreq_msg, cacheresp_msg);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({cachereq_rdy, cacheresp_val, insecure, memreq_val, memresp_rdy} !== 5'b10001) begin
      errors++; $display("FAIL post_reset_ctl got %b exp 10001",
                         {cachereq_rdy, cacheresp_val, insecure, memreq_val, memresp_rdy});
    end
  endtask

  task automatic test_high_read();
    do_txn(1'b1, 32'h0000_9000, 3'd0, 8'h3C, 4'h0, 128'h0, 0, 0, 0, {16{8'hA5}});
  endtask

  task automatic test_low_read_deny();
    do_txn(1'b0, 32'h0000_9000, 3'd0, 8'hC7, 4'h0, 128'h0, 0, 0, 0, 128'h0);
  endtask

  task automatic test_boundaries();
    do_txn(1'b0, 32'h0000_7FFC, 3'd1, 8'h11, 4'h4, {4{32'hDEADBEEF}}, 0, 1, 0, {4{32'h01234567}});
    do_txn(1'b0, 32'h0000_8000, 3'd1, 8'h22, 4'h4, {4{32'hCAFEF00D}}, 0, 0, 0, 128'h0);
    do_txn(1'b1, 32'h0000_8000, 3'd1, 8'h33, 4'h0, {4{32'h55AA55AA}}, 0, 0, 0, {4{32'h89ABCDEF}});
    do_txn(1'b0, 32'hFFFF_FFFC, 3'd0, 8'h44, 4'h0, 128'h0, 0, 0, 0, 128'h0);
    do_txn(1'b0, 32'h0000_0000, 3'd0, 8'h55, 4'h0, 128'h0, 0, 0, 0, {4{32'h0BADC0DE}});
  endtask

  task automatic test_backpressure();
    do_txn(1'b1, 32'h0000_A040, 3'd0, 8'h66, 4'h0, 128'h0, 5, 2, 3, {4{32'h13579BDF}});
    do_txn(1'b0, 32'h0000_8100, 3'd1, 8'h77, 4'h8, {4{32'h24681357}}, 0, 0, 3, 128'h0);
  endtask

  task automatic test_reset_mid();
    logic [REQ_W-1:0] req;
    req = {3'd0, 8'h99, 32'h0000_1000, 4'h0, 128'h0};
    cachereq_msg = req; cachereq_domain = 1'b0; cachereq_val = 1'b1;
    step();
    cachereq_val = 1'b0;
    step();
    memreq_rdy = 1'b1;
    step();
    memreq_rdy = 1'b0;
    checks++;
    if ({memreq_val, memresp_rdy} !== 2'b01) begin
      errors++; $display("FAIL mid_wait got %b exp 01", {memreq_val, memresp_rdy});
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({cachereq_rdy, cacheresp_val, insecure, memreq_val, memresp_rdy} !== 5'b10001) begin
      errors++; $display("FAIL mid_reset_ctl got %b exp 10001",
                         {cachereq_rdy, cacheresp_val, insecure, memreq_val, memresp_rdy});
    end
    memresp_val = 1'b1; memresp_msg = {3'd0, 8'h99, 2'b00, 4'h0, {4{32'hFEEDFACE}}};
    step();
    memresp_val = 1'b0; memresp_msg = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({cacheresp_val, cachereq_rdy, memresp_rdy} !== 3'b011) begin
        errors++; $display("FAIL stale_drop got %b exp 011", {cacheresp_val, cachereq_rdy, memresp_rdy});
      end
      step();
    end
    do_txn(1'b1, 32'h0000_C000, 3'd0, 8'h9A, 4'h0, 128'h0, 1, 1, 1, {4{32'h600DF00D}});
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: addr = HIGH_BASE - 32'd8 + 32'($urandom_range(0, 16));
        1: addr = $urandom();
        default: addr = 32'($urandom_range(0, 32'h0000_FFFF));
      endcase
      do_txn(1'($urandom_range(0, 1)), addr, 3'($urandom_range(0, 2)), 8'($urandom()),
             4'($urandom()), {$urandom(), $urandom(), $urandom(), $urandom()},
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             {$urandom(), $urandom(), $urandom(), $urandom()});
    end
  endtask

`ifdef PLAB3_MEM_SEC_GUARD_VIOL_CNT_EN
  task automatic test_viol_count();
    int expected;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (viol_count !== 8'h00) begin
      errors++; $display("FAIL viol_reset got %h exp 00", viol_count);
    end
    expected = 0;
    for (int n = 0; n < 257; n++) begin
      do_txn(1'b0, HIGH_BASE + 32'($urandom_range(0, 32'h7FFF_0000)), 3'd0, 8'(n), 4'h0, 128'h0,
             0, 0, 0, 128'h0);
      expected = (expected + 1 > 255) ? 255 : expected + 1;
      if (n == 0 || n == 254 || n == 256) begin
        checks++;
        if (viol_count !== 8'(expected)) begin
          errors++; $display("FAIL viol_count n=%0d got %h exp %h", n, viol_count, 8'(expected));
        end
      end
    end
    do_txn(1'b1, 32'h0000_9000, 3'd0, 8'h01, 4'h0, 128'h0, 0, 0, 0, 128'h1);
    checks++;
    if (viol_count !== 8'hFF) begin
      errors++; $display("FAIL viol_allowed got %h exp FF", viol_count);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (viol_count !== 8'h00) begin
      errors++; $display("FAIL viol_clear got %h exp 00", viol_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_high_read();
    test_low_read_deny();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef PLAB3_MEM_SEC_GUARD_VIOL_CNT_EN
    test_viol_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
